// File: rtl/lamp_driver.sv
// Traffic lamp driver: follows a cyclic sequencer's lamp code, dims it with PWM,
// and latches into a flashing-yellow fault mode on illegal codes or sequence jumps.
module lamp_driver #(
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [0:2] light,
  input  logic       fault_clr,
  input  logic [3:0] duty,
  output logic [0:2] lamp,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] fault_cnt
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_SEQ     = 2'b10;
  localparam logic [7:0] HALF_LAST    = 8'(FLASH_HALF - 1);

  function automatic logic code_legal(input logic [0:2] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  // Hold is always allowed; otherwise only red->green->yellow->red.
  function automatic logic step_allowed(input logic [0:2] prev, input logic [0:2] cur);
    logic ok;
    ok = (cur == prev);
    case (prev)
      3'b100:  ok = ok || (cur == 3'b010);
      3'b010:  ok = ok || (cur == 3'b001);
      3'b001:  ok = ok || (cur == 3'b100);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t     state_r, state_s;
  logic [3:0] pwm_cnt_r;
  logic [0:2] last_code_r, last_code_s;
  logic [7:0] flash_tmr_r, flash_tmr_s;
  logic       flash_on_r, flash_on_s;
  logic [0:2] lamp_r, lamp_s;
  logic       fault_r, fault_s;
  logic [1:0] fault_code_r, fault_code_s;
  logic [7:0] fault_cnt_r, fault_cnt_s;
  logic       pwm_lit_s;
  logic [0:2] gated_s;

  assign pwm_lit_s = (duty == 4'hF) || (pwm_cnt_r < duty);
  assign gated_s   = pwm_lit_s ? light : 3'b000;

  // Next-state and next-output decode.
  always_comb begin
    state_s      = state_r;
    last_code_s  = last_code_r;
    flash_tmr_s  = flash_tmr_r;
    flash_on_s   = flash_on_r;
    lamp_s       = lamp_r;
    fault_s      = fault_r;
    fault_code_s = fault_code_r;
    fault_cnt_s  = fault_cnt_r;
    case (state_r)
      ST_INIT: begin
        if (code_legal(light)) begin
          state_s     = ST_RUN;
          last_code_s = light;
          lamp_s      = gated_s;
        end else begin
          lamp_s = 3'b000;
        end
      end
      ST_RUN: begin
        last_code_s = light;
        if (code_legal(light) && step_allowed(last_code_r, light)) begin
          lamp_s = gated_s;
        end else begin
          state_s      = ST_FLASH;
          fault_s      = 1'b1;
          fault_code_s = code_legal(light) ? CODE_SEQ : CODE_ILLEGAL;
          flash_tmr_s  = 8'd0;
          flash_on_s   = 1'b1;
          lamp_s       = 3'b001;
          fault_cnt_s  = (fault_cnt_r == 8'hFF) ? fault_cnt_r : fault_cnt_r + 8'd1;
        end
      end
      ST_FLASH: begin
        if (fault_clr) begin
          state_s      = ST_INIT;
          lamp_s       = 3'b000;
          fault_s      = 1'b0;
          fault_code_s = CODE_NONE;
          flash_tmr_s  = 8'd0;
          flash_on_s   = 1'b0;
        end else if (flash_tmr_r >= HALF_LAST) begin
          flash_tmr_s = 8'd0;
          flash_on_s  = ~flash_on_r;
          lamp_s      = {2'b00, ~flash_on_r};
        end else begin
          flash_tmr_s = flash_tmr_r + 8'd1;
          lamp_s      = {2'b00, flash_on_r};
        end
      end
      default: begin
        state_s      = ST_INIT;
        lamp_s       = 3'b000;
        fault_s      = 1'b0;
        fault_code_s = CODE_NONE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_INIT;
      pwm_cnt_r    <= 4'd0;
      last_code_r  <= 3'b000;
      flash_tmr_r  <= 8'd0;
      flash_on_r   <= 1'b0;
      lamp_r       <= 3'b000;
      fault_r      <= 1'b0;
      fault_code_r <= CODE_NONE;
      fault_cnt_r  <= 8'd0;
    end else begin
      state_r      <= state_s;
      pwm_cnt_r    <= pwm_cnt_r + 4'd1;
      last_code_r  <= last_code_s;
      flash_tmr_r  <= flash_tmr_s;
      flash_on_r   <= flash_on_s;
      lamp_r       <= lamp_s;
      fault_r      <= fault_s;
      fault_code_r <= fault_code_s;
      fault_cnt_r  <= fault_cnt_s;
    end
  end

  assign lamp       = lamp_r;
  assign fault      = fault_r;
  assign fault_code = fault_code_r;
  assign fault_cnt  = fault_cnt_r;

endmodule

// File: tb/tb_lamp_driver.sv
// Bench for lamp_driver: fixed vector table, directed corner sequences and
// randomized traffic compared against a cycle-count based reference model.
module tb_lamp_driver;

  localparam int HALF = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [0:2] light;
  logic       fault_clr;
  logic [3:0] duty;
  logic [0:2] lamp;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] fault_cnt;

  lamp_driver #(.FLASH_HALF(HALF)) dut (
    .clock(clock), .reset_n(reset_n), .light(light), .fault_clr(fault_clr), .duty(duty),
    .lamp(lamp), .fault(fault), .fault_code(fault_code), .fault_cnt(fault_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:2] light;
    logic       clr;
    logic [3:0] duty;
    logic [0:2] lamp;
    logic       fault;
    logic [1:0] code;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[$];

  // Reference model: mode flags, sequence rule, cycle counters.
  bit         m_running, m_flashing, m_fault;
  logic [0:2] m_last, m_lamp;
  logic [1:0] m_code;
  int         m_cnt, m_edges, m_fk;

  function automatic logic [0:2] succ(input logic [0:2] c);
    case (c)
      3'b100:  return 3'b010;
      3'b010:  return 3'b001;
      3'b001:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit one_hot(input logic [0:2] c);
    return $countones(c) == 1;
  endfunction

  task automatic model_reset();
    m_running = 0; m_flashing = 0; m_fault = 0;
    m_last = 3'b000; m_lamp = 3'b000; m_code = 2'b00;
    m_cnt = 0; m_edges = 0; m_fk = 0;
  endtask

  task automatic model_edge();
    int pwm;
    bit lit;
    pwm = m_edges % 16;
    lit = (duty == 4'hF) || (pwm < int'(duty));
    if (m_flashing) begin
      if (fault_clr) begin
        m_flashing = 0; m_lamp = 3'b000; m_fault = 0; m_code = 2'b00;
      end else begin
        m_fk++;
        m_lamp = (((m_fk / HALF) % 2) == 0) ? 3'b001 : 3'b000;
      end
    end else if (m_running) begin
      if (one_hot(light) && (light == m_last || light == succ(m_last))) begin
        m_last = light;
        m_lamp = lit ? light : 3'b000;
      end else begin
        m_running = 0; m_flashing = 1; m_fault = 1;
        m_code = one_hot(light) ? 2'b10 : 2'b01;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_fk = 0;
        m_lamp = 3'b001;
      end
    end else if (one_hot(light)) begin
      m_running = 1;
      m_last = light;
      m_lamp = lit ? light : 3'b000;
    end
    m_edges++;
  endtask

  task automatic check(input string name, input logic [0:2] el, input logic ef,
                       input logic [1:0] ec, input logic [7:0] en);
    checks++;
    if ({lamp, fault, fault_code, fault_cnt} !== {el, ef, ec, en}) begin
      errors++;
      $display("FAIL %s: got lamp=%b fault=%b code=%b cnt=%0d, want lamp=%b fault=%b code=%b cnt=%0d",
               name, lamp, fault, fault_code, fault_cnt, el, ef, ec, en);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic step_chk(input string name);
    step();
    check(name, m_lamp, m_fault, m_code, 8'(m_cnt));
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    #1;
    model_reset();
    check(name, 3'b000, 1'b0, 2'b00, 8'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic add(input logic [0:2] l, input logic c, input logic [0:2] el,
                     input logic ef, input logic [1:0] ec, input logic [7:0] en);
    vec_t v;
    v.light = l; v.clr = c; v.duty = 4'hF;
    v.lamp = el; v.fault = ef; v.code = ec; v.cnt = en;
    tbl.push_back(v);
  endtask

  initial begin
    int lit_cnt;
    int r;
    reset_n = 1'b0; light = 3'b000; fault_clr = 1'b0; duty = 4'hF;

    // Sequencing, sequence fault, flash timing, clear, illegal code, clear racing a fault.
    add(3'b100, 1'b0, 3'b100, 1'b0, 2'b00, 8'd0);
    add(3'b010, 1'b0, 3'b010, 1'b0, 2'b00, 8'd0);
    add(3'b001, 1'b0, 3'b001, 1'b0, 2'b00, 8'd0);
    add(3'b100, 1'b0, 3'b100, 1'b0, 2'b00, 8'd0);
    add(3'b010, 1'b0, 3'b010, 1'b0, 2'b00, 8'd0);
    add(3'b100, 1'b0, 3'b001, 1'b1, 2'b10, 8'd1);
    add(3'b111, 1'b0, 3'b001, 1'b1, 2'b10, 8'd1);
    add(3'b000, 1'b0, 3'b001, 1'b1, 2'b10, 8'd1);
    add(3'b010, 1'b0, 3'b001, 1'b1, 2'b10, 8'd1);
    add(3'b000, 1'b0, 3'b000, 1'b1, 2'b10, 8'd1);
    add(3'b000, 1'b0, 3'b000, 1'b1, 2'b10, 8'd1);
    add(3'b000, 1'b0, 3'b000, 1'b1, 2'b10, 8'd1);
    add(3'b000, 1'b0, 3'b000, 1'b1, 2'b10, 8'd1);
    add(3'b000, 1'b0, 3'b001, 1'b1, 2'b10, 8'd1);
    add(3'b000, 1'b1, 3'b000, 1'b0, 2'b00, 8'd1);
    add(3'b110, 1'b0, 3'b000, 1'b0, 2'b00, 8'd1);
    add(3'b001, 1'b1, 3'b001, 1'b0, 2'b00, 8'd1);
    add(3'b001, 1'b1, 3'b001, 1'b0, 2'b00, 8'd1);
    add(3'b110, 1'b0, 3'b001, 1'b1, 2'b01, 8'd2);
    add(3'b000, 1'b1, 3'b000, 1'b0, 2'b00, 8'd2);
    add(3'b001, 1'b0, 3'b001, 1'b0, 2'b00, 8'd2);
    add(3'b010, 1'b1, 3'b001, 1'b1, 2'b10, 8'd3);
    add(3'b000, 1'b0, 3'b001, 1'b1, 2'b10, 8'd3);

    do_reset("reset_initial");
    for (int i = 0; i < tbl.size(); i++) begin
      light = tbl[i].light; fault_clr = tbl[i].clr; duty = tbl[i].duty;
      step();
      check($sformatf("vec%0d", i), tbl[i].lamp, tbl[i].fault, tbl[i].code, tbl[i].cnt);
    end

    // PWM brightness: 4/16, off, full.
    fault_clr = 1'b0;
    do_reset("reset_pwm");
    duty = 4'd4; light = 3'b100; lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step_chk("pwm_duty4");
      if (lamp == 3'b100) lit_cnt++;
    end
    check_int("pwm_duty4_lit", lit_cnt, 8);
    duty = 4'd0; lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (lamp == 3'b000) lit_cnt++;
    end
    check_int("pwm_duty0_dark", lit_cnt, 16);
    duty = 4'hF; lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (lamp == 3'b100) lit_cnt++;
    end
    check_int("pwm_dutyF_lit", lit_cnt, 16);

    // Fault counter saturation.
    do_reset("reset_sat");
    light = 3'b100;
    step_chk("sat_run");
    for (int i = 1; i <= 256; i++) begin
      light = 3'b011; fault_clr = 1'b0;
      step_chk("sat_fault");
      if (i >= 255) check_int("sat_cnt", int'(fault_cnt), 255);
      fault_clr = 1'b1;
      step_chk("sat_clear");
      fault_clr = 1'b0; light = 3'b100;
      step_chk("sat_rerun");
    end

    // Reset asserted mid-FLASH, then mid-RUN.
    light = 3'b011;
    step_chk("mid_flash_enter");
    light = 3'b000;
    step_chk("mid_flash_1");
    step_chk("mid_flash_2");
    do_reset("reset_mid_flash");
    step_chk("post_reset_init");
    light = 3'b100;
    step_chk("post_reset_run");
    light = 3'b010;
    step_chk("run_before_reset");
    do_reset("reset_mid_run");

    // Randomized traffic, mostly legal, against the model.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        if (m_running) begin
          light = ($urandom_range(0, 1) == 0) ? m_last : succ(m_last);
        end else begin
          case ($urandom_range(0, 2))
            0:       light = 3'b100;
            1:       light = 3'b010;
            default: light = 3'b001;
          endcase
        end
      end else begin
        light = 3'($urandom_range(0, 7));
      end
      fault_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) duty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset("reset_random");
      step_chk("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
